// File: rtl/prime_power_feeder.sv
// Prime power feeder: captures primes from a sieve and emits the largest p^k <= BOUND for each one.
// Define PRIME_POWER_FEEDER_OVF_CNT_EN to build the saturating dropped-prime counter on ovf_count.
module prime_power_feeder #(
  parameter int BOUND = 500,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  prime_number,
  input  logic        loop,
  output logic [15:0] pp_data,
  output logic        pp_valid,
  input  logic        pp_ready,
  output logic        done,
  output logic [7:0]  ovf_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [24:0]   BOUND25  = 25'(BOUND);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, MULT, OUT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [8:0]      r_last;
  logic            r_end_seen;
  logic [8:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [8:0]      r_p;
  logic [15:0]     r_acc;
  logic            r_done;

  logic            w_capture;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_load_ok;
  logic            w_mult_ok;
  logic [24:0]     w_prod;

  // A prime is new only if it changed since the last capture; the edge that sees loop=1 already blocks it.
  assign w_capture = (prime_number >= 9'd2) && (prime_number != r_last) && !r_end_seen && !loop;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_prod    = 25'(r_acc) * 25'(r_p);
  assign w_load_ok = (25'(r_p) <= BOUND25);
  assign w_mult_ok = (w_prod <= BOUND25);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= '0;
      r_end_seen <= 1'b0;
    end else begin
      if (w_capture) r_last <= prime_number;
      if (loop)      r_end_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= prime_number;
  end

  // When full, push and pop share a slot; the pop reads the old entry before it is overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    pp_valid = 1'b0;
    pp_data  = '0;
    unique case (r_state)
      IDLE: if (!w_empty) w_next = LOAD;
      LOAD: w_next = w_load_ok ? MULT : IDLE;
      MULT: if (!w_mult_ok) w_next = OUT;
      OUT: begin
        pp_valid = 1'b1;
        pp_data  = r_acc;
        if (pp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p   <= '0;
      r_acc <= '0;
    end else begin
      if (w_pop) r_p <= r_mem[r_rptr];
      if ((r_state == LOAD) && w_load_ok) r_acc <= 16'(r_p);
      if ((r_state == MULT) && w_mult_ok) r_acc <= w_prod[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else if (r_end_seen && w_empty && (r_state == IDLE)) r_done <= 1'b1;
  end

  assign done = r_done;

`ifdef PRIME_POWER_FEEDER_OVF_CNT_EN
  logic       w_drop;
  logic [7:0] r_ovf;

  assign w_drop = w_capture && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= '0;
    else if (w_drop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
  end

  assign ovf_count = r_ovf;
`else
  assign ovf_count = 8'd0;
`endif

endmodule
